// File: rtl/modbus_frame_tx.sv
// Modbus RTU response framer: streams payload bytes from DPRAM to the byte UART,
// folds each byte into CRC-16/Modbus bit-serially, appends the CRC and holds the line quiet for t3.5.
module modbus_frame_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int A_WIDTH    = 8,
  parameter int BASE_ADDR  = 0,
  parameter int T35_CYCLES = (CLK_FREQ / BAUD_RATE) * 39
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               tx_start,
  input  logic [7:0]         tx_quantity,
  output logic [A_WIDTH-1:0] dpram_raddr,
  input  logic [15:0]        dpram_rdata,
  output logic               uart_tx_start,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_done,
  output logic               rs485_de,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_err
);

  localparam int GAP_W = $clog2(T35_CYCLES + 2);

  typedef enum logic [3:0] {
    IDLE, RD, RD_WAIT, CRC, SEND, WAIT_DONE,
    CRC_LO, CRC_LO_WAIT, CRC_HI, CRC_HI_WAIT, GAP, DONE
  } state_t;

  state_t           state;
  logic [7:0]       qty;
  logic [7:0]       idx;
  logic [15:0]      crc;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic             phase;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       sel_byte;

  // Even payload bytes sit in the high half of a word, odd ones in the low half.
  assign sel_byte = idx[0] ? dpram_rdata[7:0] : dpram_rdata[15:8];

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic [15:0] s;
    s = c >> 1;
    if (c[0] ^ b) s = s ^ 16'hA001;
    return s;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      dpram_raddr   <= A_WIDTH'(BASE_ADDR);
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
      rs485_de      <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      qty           <= 8'h00;
      idx           <= 8'h00;
      crc           <= 16'hFFFF;
      shreg         <= 8'h00;
      bit_cnt       <= 3'd0;
      phase         <= 1'b0;
      gap_cnt       <= '0;
    end else begin
      uart_tx_start <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            if (tx_quantity >= 8'd2 && tx_quantity <= 8'd254) begin
              qty      <= tx_quantity;
              idx      <= 8'h00;
              crc      <= 16'hFFFF;
              busy     <= 1'b1;
              rs485_de <= 1'b1;
              state    <= RD;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        RD: begin
          dpram_raddr <= A_WIDTH'(BASE_ADDR) + A_WIDTH'(idx[7:1]);
          phase       <= 1'b0;
          state       <= RD_WAIT;
        end
        // One cycle for the RAM to register the address, then take the byte.
        RD_WAIT: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            uart_tx_data <= sel_byte;
            shreg        <= sel_byte;
            bit_cnt      <= 3'd0;
            state        <= CRC;
          end
        end
        CRC: begin
          crc     <= crc_step(crc, shreg[0]);
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            uart_tx_start <= 1'b1;
            idx           <= idx + 8'd1;
            state         <= SEND;
          end
        end
        SEND: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (uart_tx_done) begin
            phase <= 1'b0;
            state <= (idx == qty) ? CRC_LO : RD;
          end
        end
        CRC_LO: begin
          if (!phase) begin
            uart_tx_data <= crc[7:0];
            phase        <= 1'b1;
          end else begin
            uart_tx_start <= 1'b1;
            state         <= CRC_LO_WAIT;
          end
        end
        CRC_LO_WAIT: begin
          if (uart_tx_done) begin
            phase <= 1'b0;
            state <= CRC_HI;
          end
        end
        CRC_HI: begin
          if (!phase) begin
            uart_tx_data <= crc[15:8];
            phase        <= 1'b1;
          end else begin
            uart_tx_start <= 1'b1;
            state         <= CRC_HI_WAIT;
          end
        end
        CRC_HI_WAIT: begin
          if (uart_tx_done) begin
            gap_cnt <= GAP_W'(T35_CYCLES);
            state   <= GAP;
          end
        end
        GAP: begin
          rs485_de <= 1'b0;
          if (gap_cnt == '0) state <= DONE;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Scoreboard bench for modbus_frame_tx: DPRAM and byte-UART models, byte/CRC and timing checks.
module tb_modbus_frame_tx;

  localparam int T35      = 40;
  localparam int UART_LAT = 20;
  localparam int TMO      = 5000;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        tx_start;
  logic [7:0]  tx_quantity;
  logic [7:0]  dpram_raddr;
  logic [15:0] dpram_rdata;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_done;
  logic        rs485_de;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [256];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int          start_cycs[$];
  int          done_cycs[$];
  int          cyc = 0;
  int          ucnt = 0;
  int          last_done_cyc = 0;
  int          de_fall_cyc = 0;
  int          fd_cyc = 0;
  int          err_cyc = 0;
  int          err_cnt = 0;
  logic        de_q = 1'b0;

  modbus_frame_tx #(.A_WIDTH(8), .BASE_ADDR(0), .T35_CYCLES(T35)) dut (
    .clk_in(clk), .rst_in(rst_in), .tx_start(tx_start), .tx_quantity(tx_quantity),
    .dpram_raddr(dpram_raddr), .dpram_rdata(dpram_rdata),
    .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data), .uart_tx_done(uart_tx_done),
    .rs485_de(rs485_de), .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dpram_rdata <= mem[dpram_raddr];

  // UART stand-in plus event monitor; each event is stamped with the edge index that saw it.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    uart_tx_done <= 1'b0;
    if (ucnt != 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) uart_tx_done <= 1'b1;
    end else if (uart_tx_start) begin
      ucnt <= UART_LAT;
    end
    if (uart_tx_start) begin
      rx_q.push_back(uart_tx_data);
      start_cycs.push_back(cyc);
    end
    if (uart_tx_done) begin
      done_cycs.push_back(cyc);
      last_done_cyc <= cyc;
    end
    de_q <= rs485_de;
    if (de_q && !rs485_de) de_fall_cyc <= cyc;
    if (frame_done) fd_cyc <= cyc;
    if (frame_err) begin
      err_cyc <= cyc;
      err_cnt <= err_cnt + 1;
    end
  end

  task automatic push_model(input int qty);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = 0; i < qty; i++) begin
      b = i[0] ? mem[i >> 1][7:0] : mem[i >> 1][15:8];
      exp_q.push_back(b);
      c = c ^ {8'h00, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
  endtask

  task automatic push_literal(input logic [63:0] v);
    for (int i = 7; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
  endtask

  task automatic run_frame(input int qty, input bit mid_start, input string tag);
    int req, t, e0;
    logic [7:0] got, want;
    rx_q.delete(); start_cycs.delete(); done_cycs.delete();
    e0 = err_cnt;
    @(negedge clk);
    tx_quantity = 8'(qty);
    tx_start = 1'b1;
    @(posedge clk);
    #1 req = cyc - 1;
    @(negedge clk);
    tx_start = 1'b0;
    if (mid_start) begin
      repeat (30) @(negedge clk);
      tx_quantity = 8'd6;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
    end
    t = 0;
    while (!frame_done && t < TMO) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= TMO) begin
      failures++;
      $display("FAIL %s frame_done timeout: got none within %0d cycles", tag, TMO);
      exp_q.delete();
      return;
    end
    @(posedge clk);
    #1;
    checks++;
    if (rx_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s byte_count got=%0d exp=%0d", tag, rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = rx_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL %s byte got=%02h exp=%02h", tag, got, want);
      end
    end
    exp_q.delete();
    if (start_cycs.size() == qty + 2 && done_cycs.size() == qty + 2) begin
      checks++;
      if (start_cycs[0] - req !== 12) begin
        failures++;
        $display("FAIL %s first_start_latency got=%0d exp=11", tag, start_cycs[0] - req - 1);
      end
      for (int j = 0; j + 1 < qty; j++) begin
        checks++;
        if (start_cycs[j+1] - done_cycs[j] !== 12) begin
          failures++;
          $display("FAIL %s byte_gap[%0d] got=%0d exp=11", tag, j, start_cycs[j+1] - done_cycs[j] - 1);
        end
      end
      checks++;
      if (start_cycs[qty] - done_cycs[qty-1] !== 3) begin
        failures++;
        $display("FAIL %s crc_lo_gap got=%0d exp=2", tag, start_cycs[qty] - done_cycs[qty-1] - 1);
      end
      checks++;
      if (start_cycs[qty+1] - done_cycs[qty] !== 3) begin
        failures++;
        $display("FAIL %s crc_hi_gap got=%0d exp=2", tag, start_cycs[qty+1] - done_cycs[qty] - 1);
      end
    end
    checks++;
    if (de_fall_cyc - last_done_cyc !== 2) begin
      failures++;
      $display("FAIL %s de_fall got=%0d exp=1", tag, de_fall_cyc - last_done_cyc - 1);
    end
    checks++;
    if (fd_cyc - last_done_cyc !== T35 + 3) begin
      failures++;
      $display("FAIL %s frame_done_delay got=%0d exp=%0d", tag, fd_cyc - last_done_cyc - 1, T35 + 2);
    end
    checks++;
    if (busy !== 1'b0 || err_cnt !== e0) begin
      failures++;
      $display("FAIL %s idle_after busy=%b errs=%0d exp busy=0 errs=%0d", tag, busy, err_cnt - e0, 0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({dpram_raddr, uart_tx_start, uart_tx_data, rs485_de, busy, frame_done, frame_err} !== 21'h0) begin
      failures++;
      $display("FAIL reset_state raddr=%0h st=%b data=%0h de=%b busy=%b fd=%b fe=%b exp all 0",
               dpram_raddr, uart_tx_start, uart_tx_data, rs485_de, busy, frame_done, frame_err);
    end
  endtask

  task automatic test_read_frame();
    mem[0] = 16'h0103; mem[1] = 16'h0001; mem[2] = 16'h0001;
    push_literal(64'h01_03_00_01_00_01_D5_CA);
    run_frame(6, 1'b0, "read_frame");
  endtask

  task automatic test_write_frames();
    mem[0] = 16'h0106; mem[1] = 16'h0002; mem[2] = 16'h0005;
    push_literal(64'h01_06_00_02_00_05_E8_09);
    run_frame(6, 1'b0, "write_frame");
  endtask

  task automatic test_back_to_back();
    mem[0] = 16'h0104; mem[1] = 16'h0001; mem[2] = 16'h0004;
    push_literal(64'h01_04_00_01_00_04_A0_09);
    run_frame(6, 1'b0, "back_to_back");
  endtask

  task automatic test_odd_quantity();
    mem[0] = 16'h0103; mem[1] = 16'h0001; mem[2] = 16'h00A7;
    push_model(5);
    run_frame(5, 1'b0, "odd_qty");
  endtask

  task automatic test_bad_quantity();
    logic [7:0] bad [3] = '{8'd0, 8'd1, 8'd255};
    int req, e0, s0;
    bit act;
    for (int i = 0; i < 3; i++) begin
      e0 = err_cnt;
      s0 = start_cycs.size();
      act = 1'b0;
      @(negedge clk);
      tx_quantity = bad[i];
      tx_start = 1'b1;
      @(posedge clk);
      #1 req = cyc - 1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (busy || rs485_de) act = 1'b1;
      end
      checks++;
      if (err_cnt !== e0 + 1 || err_cyc - req !== 1) begin
        failures++;
        $display("FAIL bad_qty_%0d frame_err pulses=%0d delay=%0d exp pulses=1 delay=1",
                 bad[i], err_cnt - e0, err_cyc - req);
      end
      checks++;
      if (act || start_cycs.size() !== s0) begin
        failures++;
        $display("FAIL bad_qty_%0d activity busy/de=%b starts=%0d exp 0/0", bad[i], act, start_cycs.size() - s0);
      end
    end
  endtask

  task automatic test_busy_ignore();
    mem[0] = 16'h0103; mem[1] = 16'h0001; mem[2] = 16'h0001;
    push_literal(64'h01_03_00_01_00_01_D5_CA);
    run_frame(6, 1'b1, "busy_ignore");
  endtask

  task automatic test_mid_reset();
    int t;
    mem[0] = 16'h0106; mem[1] = 16'h0002; mem[2] = 16'h0005;
    done_cycs.delete();
    @(negedge clk);
    tx_quantity = 8'd6;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    t = 0;
    while (done_cycs.size() < 2 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({dpram_raddr, uart_tx_start, uart_tx_data, rs485_de, busy, frame_done, frame_err} !== 21'h0) begin
      failures++;
      $display("FAIL mid_reset raddr=%0h st=%b data=%0h de=%b busy=%b fd=%b fe=%b exp all 0",
               dpram_raddr, uart_tx_start, uart_tx_data, rs485_de, busy, frame_done, frame_err);
    end
    @(negedge clk);
    rst_in = 1'b0;
    repeat (UART_LAT + 5) @(negedge clk);
    mem[0] = 16'h0104; mem[1] = 16'h0001; mem[2] = 16'h0004;
    push_literal(64'h01_04_00_01_00_04_A0_09);
    run_frame(6, 1'b0, "after_reset");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst_in = 1'b1;
    tx_start = 1'b0;
    tx_quantity = 8'd0;
    repeat (4) @(negedge clk);
    test_reset();
    rst_in = 1'b0;
    repeat (2) @(negedge clk);
    test_read_frame();
    test_write_frames();
    test_back_to_back();
    test_odd_quantity();
    test_bad_quantity();
    test_busy_ignore();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
